// File: rtl/move_scanner_if.sv
// move_scanner_if: start/result handshake and board read port of the move scanner.
interface move_scanner_if #(
  parameter int COORD_W = 3,
  parameter int FLIP_W  = 6
);
  logic               start;
  logic               side;
  logic [COORD_W-1:0] x_in;
  logic [COORD_W-1:0] y_in;
  logic               rd_en;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic [1:0]         rd_data;
  logic               busy;
  logic               done;
  logic [7:0]         dir;
  logic [FLIP_W-1:0]  flip_count;
  logic               legal;
  modport master (
    output start, side, x_in, y_in, rd_data,
    input  rd_en, rd_x, rd_y, busy, done, dir, flip_count, legal
  );
  modport slave (
    input  start, side, x_in, y_in, rd_data,
    output rd_en, rd_x, rd_y, busy, done, dir, flip_count, legal
  );
endinterface

// File: rtl/move_scanner.sv
// move_scanner: walks the eight rays from a candidate cell and reports which ones capture
// opponent disks and how many disks in total.
module move_scanner #(
  parameter int BOARD_N = 8,
  parameter int COORD_W = 3,
  parameter int FLIP_W  = 6
) (
  input  logic          clock,
  input  logic          resetn,
  move_scanner_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_ORIGIN, EV_ORIGIN, STEP, RD_CELL, EV_CELL, NEXT_DIR, DONE} state_t;
  localparam int SW = FLIP_W + COORD_W + 2;
  localparam logic [COORD_W:0] NB = (COORD_W+1)'(BOARD_N);
  localparam logic [COORD_W:0] P1 = (COORD_W+1)'(1);
  localparam logic [COORD_W:0] M1 = '1;
  state_t             state_q;
  logic               side_q;
  logic [COORD_W-1:0] ox_q, oy_q;
  logic [COORD_W:0]   px_q, py_q, run_q;
  logic [2:0]         k_q;
  logic [2:0]         kk_d;
  logic [COORD_W:0]   step_x_d, step_y_d, first_x_d, first_y_d;
  logic               off_d;
  logic [SW-1:0]      sum_d;
  logic [FLIP_W-1:0]  flip_d;
  logic [1:0]         opp_d, own_d;
  // Positions carry one extra bit so a step past either edge lands at >= BOARD_N instead of wrapping.
  function automatic logic [COORD_W:0] dx(input logic [2:0] k);
    return (k == 3'd0 || k == 3'd4) ? '0 : (k < 3'd4) ? P1 : M1;
  endfunction
  function automatic logic [COORD_W:0] dy(input logic [2:0] k);
    return (k == 3'd2 || k == 3'd6) ? '0 : (k < 3'd2 || k == 3'd7) ? M1 : P1;
  endfunction
  always_comb begin
    kk_d      = (state_q == NEXT_DIR) ? k_q + 3'd1 : k_q;
    first_x_d = {1'b0, ox_q} + dx(kk_d);
    first_y_d = {1'b0, oy_q} + dy(kk_d);
    step_x_d  = px_q + dx(k_q);
    step_y_d  = py_q + dy(k_q);
    off_d     = (px_q >= NB) || (py_q >= NB);
    sum_d     = SW'(bus.flip_count) + SW'(run_q);
    flip_d    = (sum_d > SW'({FLIP_W{1'b1}})) ? '1 : sum_d[FLIP_W-1:0];
    opp_d     = side_q ? 2'b01 : 2'b10;
    own_d     = side_q ? 2'b10 : 2'b01;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      side_q         <= 1'b0;
      ox_q           <= '0;
      oy_q           <= '0;
      px_q           <= '0;
      py_q           <= '0;
      run_q          <= '0;
      k_q            <= '0;
      bus.rd_en      <= 1'b0;
      bus.rd_x       <= '0;
      bus.rd_y       <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.dir        <= 8'h00;
      bus.flip_count <= '0;
      bus.legal      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          side_q         <= bus.side;
          ox_q           <= bus.x_in;
          oy_q           <= bus.y_in;
          k_q            <= '0;
          bus.busy       <= 1'b1;
          bus.dir        <= 8'h00;
          bus.flip_count <= '0;
          bus.legal      <= 1'b0;
          if ({1'b0, bus.x_in} >= NB || {1'b0, bus.y_in} >= NB) begin
            bus.done <= 1'b1;
            state_q  <= DONE;
          end else begin
            bus.rd_en <= 1'b1;
            bus.rd_x  <= bus.x_in;
            bus.rd_y  <= bus.y_in;
            state_q   <= RD_ORIGIN;
          end
        end
        RD_ORIGIN: begin
          bus.rd_en <= 1'b0;
          state_q   <= EV_ORIGIN;
        end
        EV_ORIGIN: if (bus.rd_data == 2'b01 || bus.rd_data == 2'b10) begin
          bus.done <= 1'b1;
          state_q  <= DONE;
        end else begin
          px_q    <= first_x_d;
          py_q    <= first_y_d;
          run_q   <= '0;
          state_q <= STEP;
        end
        STEP: if (off_d) state_q <= NEXT_DIR;
        else begin
          bus.rd_en <= 1'b1;
          bus.rd_x  <= px_q[COORD_W-1:0];
          bus.rd_y  <= py_q[COORD_W-1:0];
          state_q   <= RD_CELL;
        end
        RD_CELL: begin
          bus.rd_en <= 1'b0;
          state_q   <= EV_CELL;
        end
        EV_CELL: if (bus.rd_data == opp_d) begin
          run_q   <= run_q + P1;
          px_q    <= step_x_d;
          py_q    <= step_y_d;
          state_q <= STEP;
        end else begin
          if (bus.rd_data == own_d && run_q != '0) begin
            bus.dir[k_q]   <= 1'b1;
            bus.legal      <= 1'b1;
            bus.flip_count <= flip_d;
          end
          state_q <= NEXT_DIR;
        end
        NEXT_DIR: if (k_q == 3'd7) begin
          bus.done <= 1'b1;
          state_q  <= DONE;
        end else begin
          k_q     <= kk_d;
          px_q    <= first_x_d;
          py_q    <= first_y_d;
          run_q   <= '0;
          state_q <= STEP;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_move_scanner.sv
// tb_move_scanner: random boards and candidates scanned by the DUT and compared with a
// ray-walking reference model, plus directed opening/edge/reset scenarios.
module tb_move_scanner;
  localparam int N = 8;
  localparam int CW = 4;
  localparam int FW = 6;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  move_scanner_if #(.COORD_W(CW), .FLIP_W(FW)) bus ();
  move_scanner #(.BOARD_N(N), .COORD_W(CW), .FLIP_W(FW)) dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;
  logic [1:0] board [N][N];
  int dxs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dys [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
  int total = 0;
  int bad = 0;
  int nreads = 0;
  logic [7:0] res_dir;
  int res_flip;
  logic res_legal;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clock) begin
    if (bus.rd_en) begin
      nreads++;
      chk("rd_addr_in_range", 32'(bus.rd_x < CW'(N) && bus.rd_y < CW'(N)), 32'd1);
      bus.rd_data <= board[bus.rd_y[2:0]][bus.rd_x[2:0]];
    end
  end
  function automatic logic on_board(input int x, input int y);
    return x >= 0 && x < N && y >= 0 && y < N;
  endfunction
  function automatic void model(input logic s, input int x, input int y,
                                output logic [7:0] d, output int f, output int nr);
    logic [1:0] opp, own;
    d = 8'h00; f = 0; nr = 0;
    if (x >= N || y >= N) return;
    nr = 1;
    if (board[y][x] == 2'b01 || board[y][x] == 2'b10) return;
    opp = s ? 2'b01 : 2'b10;
    own = s ? 2'b10 : 2'b01;
    for (int k = 0; k < 8; k++) begin
      int cx, cy, n;
      cx = x + dxs[k]; cy = y + dys[k]; n = 0;
      while (on_board(cx, cy) && board[cy][cx] == opp) begin
        nr++; n++; cx += dxs[k]; cy += dys[k];
      end
      if (on_board(cx, cy)) begin
        nr++;
        if (board[cy][cx] == own && n > 0) begin
          d[k] = 1'b1;
          f += n;
        end
      end
    end
    if (f > 63) f = 63;
  endfunction
  task automatic clear_board();
    for (int y = 0; y < N; y++) for (int x = 0; x < N; x++) board[y][x] = 2'b00;
  endtask
  task automatic opening();
    clear_board();
    board[3][3] = 2'b10; board[4][4] = 2'b10; board[4][3] = 2'b01; board[3][4] = 2'b01;
  endtask
  task automatic run_scan(input logic s, input int x, input int y, input logic scramble);
    logic [7:0] md;
    int mf, mr, cyc;
    logic occ;
    model(s, x, y, md, mf, mr);
    occ = (x < N && y < N) && (board[y][x] == 2'b01 || board[y][x] == 2'b10);
    @(negedge clock);
    bus.side = s; bus.x_in = CW'(x); bus.y_in = CW'(y); bus.start = 1'b1;
    nreads = 0;
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    while (!bus.done && cyc < 400) begin
      if (scramble) begin
        bus.side = 1'($urandom); bus.x_in = CW'($urandom); bus.y_in = CW'($urandom);
        bus.start = 1'($urandom);
      end
      @(negedge clock);
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("dir", 32'(bus.dir), 32'(md));
    chk("flip_count", 32'(bus.flip_count), 32'(mf));
    chk("legal", 32'(bus.legal), 32'(md != 8'h00));
    chk("read_count", 32'(nreads), 32'(mr));
    if (x >= N || y >= N) chk("oor_latency", 32'(cyc), 32'd1);
    else if (occ) chk("occupied_latency", 32'(cyc), 32'd3);
    else chk("latency_bound", 32'(cyc <= 3 + 8 * (3 * N)), 32'd1);
    res_dir = bus.dir; res_flip = int'(bus.flip_count); res_legal = bus.legal;
    @(negedge clock);
    chk("busy_cleared", 32'(bus.busy), 32'd0);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("dir_hold", 32'(bus.dir), 32'(md));
    @(negedge clock);
    chk("flip_hold", 32'(bus.flip_count), 32'(mf));
  endtask
  initial begin
    logic [7:0] md;
    int mf, mr;
    logic seen_done;
    bus.start = 1'b0; bus.side = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.rd_data = 2'b00;
    clear_board();
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_dir", 32'(bus.dir), 32'd0);
    chk("rst_flip", 32'(bus.flip_count), 32'd0);
    chk("rst_legal", 32'(bus.legal), 32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    opening();
    model(1'b0, 3, 2, md, mf, mr);
    chk("model_open_dir", 32'(md), 32'h10);
    chk("model_open_flip", 32'(mf), 32'd1);
    run_scan(1'b0, 3, 2, 1'b0);
    chk("open_dir_lit", 32'(res_dir), 32'h10);
    chk("open_flip_lit", 32'(res_flip), 32'd1);
    chk("open_legal_lit", 32'(res_legal), 32'd1);
    run_scan(1'b0, 0, 0, 1'b0);
    chk("corner_dir_lit", 32'(res_dir), 32'h00);
    run_scan(1'b0, 3, 3, 1'b0);
    chk("occ_reads_lit", 32'(nreads), 32'd1);
    chk("occ_legal_lit", 32'(res_legal), 32'd0);
    run_scan(1'b0, 8, 2, 1'b0);
    chk("oor_reads_lit", 32'(nreads), 32'd0);
    chk("oor_legal_lit", 32'(res_legal), 32'd0);
    clear_board();
    board[0][0] = 2'b01;
    for (int x = 1; x <= 6; x++) board[0][x] = 2'b10;
    model(1'b0, 7, 0, md, mf, mr);
    chk("model_row_dir", 32'(md), 32'h40);
    chk("model_row_flip", 32'(mf), 32'd6);
    run_scan(1'b0, 7, 0, 1'b1);
    chk("row_dir_lit", 32'(res_dir), 32'h40);
    chk("row_flip_lit", 32'(res_flip), 32'd6);
    opening();
    @(negedge clock);
    bus.side = 1'b0; bus.x_in = CW'(3); bus.y_in = CW'(2); bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (20) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_dir", 32'(bus.dir), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge clock);
      seen_done |= bus.done;
    end
    chk("midrst_no_done", 32'(seen_done), 32'd0);
    run_scan(1'b0, 3, 2, 1'b0);
    chk("rerun_dir_lit", 32'(res_dir), 32'h10);
    chk("rerun_flip_lit", 32'(res_flip), 32'd1);
    for (int t = 0; t < 150; t++) begin
      for (int y = 0; y < N; y++)
        for (int x = 0; x < N; x++) begin
          int r;
          r = int'($urandom_range(0, 9));
          board[y][x] = r < 3 ? 2'b00 : r < 6 ? 2'b10 : r < 9 ? 2'b01 : 2'b11;
        end
      if ($urandom_range(0, 3) != 0) begin
        int ox, oy;
        ox = int'($urandom_range(0, N - 1)); oy = int'($urandom_range(0, N - 1));
        board[oy][ox] = 2'b00;
      end
      run_scan(1'($urandom), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
